pc_sequencer: RTL and testbench

//  Controller that drives the program counter's stall, PCWrite and PCSrc inputs.

---
 rtl/pc_ctrl_defs.sv | 6 +
 rtl/redirect_arbiter.sv | 25 ++
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 104 ++++++++++
 4 files changed

// File: rtl/pc_ctrl_defs.sv
// pc_ctrl_defs: shared encodings for the PC sequencer and redirect arbiter
package pc_ctrl_defs;
  localparam int XLEN_DEF = 32;
  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_PEND} state_t;
  typedef enum logic [1:0] {K_NONE = 2'd0, K_JMP = 2'd1, K_BR = 2'd2, K_TRAP = 2'd3} kind_t;
endpackage

// File: rtl/redirect_arbiter.sv
// redirect_arbiter: priority select of trap > branch > jump redirect requests
import pc_ctrl_defs::*;
module redirect_arbiter #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_target,
  input  logic            br_req,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_req,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            hz_stall,
  output logic            valid,
  output kind_t           kind,
  output logic [XLEN-1:0] target
);
  logic jmp_ok;
  // a jump decoded in ID is meaningless while ID itself is stalled
  always_comb begin
    jmp_ok = jmp_req & ~hz_stall;
    valid  = trap_req | br_req | jmp_ok;
    kind   = trap_req ? K_TRAP : br_req ? K_BR : jmp_ok ? K_JMP : K_NONE;
    target = trap_req ? trap_target : br_req ? br_target : jmp_ok ? jmp_target : '0;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: drives PC stall/write/source, holding redirects that meet a stall
import pc_ctrl_defs::*;
module pc_sequencer #(
  parameter int XLEN       = XLEN_DEF,
  parameter int BOOT_DELAY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_target,
  input  logic            br_req,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_req,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            hz_stall,
  input  logic            imem_ready,
  output logic            stall,
  output logic            pc_write,
  output logic [XLEN-1:0] pc_src,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            redirect_pending
);
  localparam int CW = $clog2(BOOT_DELAY + 1);
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] pend_t_q, pend_t_d;
  kind_t           pend_k_q, pend_k_d;
  logic            req_v, blocked;
  kind_t           req_k, eff_k, app_k;
  logic [XLEN-1:0] req_t, eff_t, app_t;
  redirect_arbiter #(.XLEN(XLEN)) u_arb (
    .trap_req(trap_req), .trap_target(trap_target),
    .br_req(br_req), .br_target(br_target),
    .jmp_req(jmp_req), .jmp_target(jmp_target),
    .hz_stall(hz_stall),
    .valid(req_v), .kind(req_k), .target(req_t)
  );
  // state register; reset is folded into the next-state logic
  always_ff @(posedge clk) begin
    state_q  <= state_d;
    cnt_q    <= cnt_d;
    pend_t_q <= pend_t_d;
    pend_k_q <= pend_k_d;
  end
  // next state, pending latch and PC control
  always_comb begin
    stall    = 1'b1;
    pc_write = 1'b0;
    app_t    = '0;
    app_k    = K_NONE;
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_t_d = pend_t_q;
    pend_k_d = pend_k_q;
    blocked  = ~imem_ready | (hz_stall & ~(trap_req | br_req));
    eff_k    = (req_v && req_k > pend_k_q) ? req_k : pend_k_q;
    eff_t    = (req_v && req_k > pend_k_q) ? req_t : pend_t_q;
    if (!rst) begin
      state_d  = ST_BOOT;
      cnt_d    = CW'(BOOT_DELAY);
      pend_t_d = '0;
      pend_k_d = K_NONE;
    end else begin
      case (state_q)
        ST_BOOT: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!req_v) stall = blocked;
          else if (!blocked) begin
            stall    = 1'b0;
            pc_write = 1'b1;
            app_t    = req_t;
            app_k    = req_k;
          end else begin
            pend_t_d = req_t;
            pend_k_d = req_k;
            state_d  = ST_PEND;
          end
        end
        ST_PEND: begin
          stall = ~imem_ready;
          if (imem_ready) begin
            pc_write = 1'b1;
            app_t    = eff_t;
            app_k    = eff_k;
            pend_k_d = K_NONE;
            state_d  = ST_RUN;
          end else begin
            pend_t_d = eff_t;
            pend_k_d = eff_k;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
    pc_src           = pc_write ? {app_t[XLEN-1:2], 2'b00} : '0;
    flush_ifid       = pc_write;
    flush_idex       = pc_write & (app_k != K_JMP);
    redirect_pending = rst & (state_q == ST_PEND);
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of boot, redirect arbitration and pending redirects
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        trap_req, br_req, jmp_req, hz_stall, imem_ready;
  logic [31:0] trap_target, br_target, jmp_target;
  logic        stall, pc_write, flush_ifid, flush_idex, redirect_pending;
  logic [31:0] pc_src;
  logic [31:0] pc;
  int          n_tests = 0;
  int          n_fail = 0;
  pc_sequencer #(.XLEN(32), .BOOT_DELAY(2)) dut (
    .clk(clk), .rst(rst),
    .trap_req(trap_req), .trap_target(trap_target),
    .br_req(br_req), .br_target(br_target),
    .jmp_req(jmp_req), .jmp_target(jmp_target),
    .hz_stall(hz_stall), .imem_ready(imem_ready),
    .stall(stall), .pc_write(pc_write), .pc_src(pc_src),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .redirect_pending(redirect_pending)
  );
  always #5 clk = ~clk;
  // reference program counter fed by the sequencer outputs
  always_ff @(posedge clk) begin
    if (!rst) pc <= '0;
    else if (!stall) pc <= pc_write ? pc_src : pc + 32'd4;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic ctl(input string tag, input logic s, input logic w, input logic [31:0] src,
                     input logic fi, input logic fe, input logic p);
    chk({tag, ".stall"}, 32'(stall), 32'(s));
    chk({tag, ".pc_write"}, 32'(pc_write), 32'(w));
    chk({tag, ".pc_src"}, pc_src, src);
    chk({tag, ".flush_ifid"}, 32'(flush_ifid), 32'(fi));
    chk({tag, ".flush_idex"}, 32'(flush_idex), 32'(fe));
    chk({tag, ".pending"}, 32'(redirect_pending), 32'(p));
  endtask
  task automatic idle();
    trap_req = 0; br_req = 0; jmp_req = 0; hz_stall = 0;
    trap_target = '0; br_target = '0; jmp_target = '0;
  endtask
  initial begin
    rst = 0; imem_ready = 1; idle();
    cyc(); cyc();
    #1 ctl("in_reset", 1, 0, 0, 0, 0, 0);
    rst = 1;
    #1 ctl("boot1", 1, 0, 0, 0, 0, 0);
    cyc(); #1 ctl("boot2", 1, 0, 0, 0, 0, 0);
    cyc(); #1 ctl("run_idle", 0, 0, 0, 0, 0, 0);
    chk("pc0", pc, 32'h0);
    cyc(); chk("pc4", pc, 32'h4);
    cyc(); chk("pc8", pc, 32'h8);
    br_req = 1; br_target = 32'h0000_0103;
    #1 ctl("br", 0, 1, 32'h100, 1, 1, 0);
    cyc(); idle(); chk("pc_br", pc, 32'h100);
    jmp_req = 1; jmp_target = 32'h40; hz_stall = 1;
    #1 ctl("jmp_hz1", 1, 0, 0, 0, 0, 0);
    cyc(); #1 ctl("jmp_hz2", 1, 0, 0, 0, 0, 0);
    cyc(); chk("pc_hold", pc, 32'h100);
    hz_stall = 0;
    #1 ctl("jmp_go", 0, 1, 32'h40, 1, 0, 0);
    cyc(); idle(); chk("pc_jmp", pc, 32'h40);
    imem_ready = 0; br_req = 1; br_target = 32'h200;
    #1 ctl("br_blk", 1, 0, 0, 0, 0, 0);
    cyc(); idle(); trap_req = 1; trap_target = 32'h80;
    #1 ctl("pend_trap", 1, 0, 0, 0, 0, 1);
    cyc(); idle(); imem_ready = 1;
    #1 ctl("pend_apply", 0, 1, 32'h80, 1, 1, 1);
    cyc(); chk("pc_trap", pc, 32'h80);
    #1 ctl("back_run", 0, 0, 0, 0, 0, 0);
    imem_ready = 0; trap_req = 1; trap_target = 32'h80;
    cyc(); idle(); br_req = 1; br_target = 32'h300;
    #1 ctl("pend_br_drop", 1, 0, 0, 0, 0, 1);
    cyc(); imem_ready = 1;
    #1 ctl("pend_keep_trap", 0, 1, 32'h80, 1, 1, 1);
    cyc(); idle();
    trap_req = 1; trap_target = 32'h1F0; br_req = 1; br_target = 32'h2F0;
    jmp_req = 1; jmp_target = 32'h3F0;
    #1 ctl("triple", 0, 1, 32'h1F0, 1, 1, 0);
    cyc(); idle(); chk("pc_triple", pc, 32'h1F0);
    imem_ready = 0; br_req = 1; br_target = 32'h200;
    cyc(); idle();
    #1 chk("pend_pre_rst", 32'(redirect_pending), 32'h1);
    rst = 0;
    #1 ctl("rst_in_pend", 1, 0, 0, 0, 0, 0);
    cyc(); rst = 1; imem_ready = 1;
    #1 ctl("reboot1", 1, 0, 0, 0, 0, 0);
    cyc(); #1 ctl("reboot2", 1, 0, 0, 0, 0, 0);
    cyc(); #1 ctl("rerun", 0, 0, 0, 0, 0, 0);
    chk("pc_rerun", pc, 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
